// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises and debounces the five/ten sensors, then emits one
// registered coin code (or a reject pulse) per insertion, with release and hold-off guards.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES      = 4,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_five,
  input  logic       sense_ten,
  output logic [1:0] coin,
  output logic       reject,
  output logic       busy,
  output logic [7:0] accepted_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StQual,
    StEmit,
    StWaitRel,
    StGap
  } state_e;

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       coin_q, coin_d;
  logic             reject_q, reject_d;
  logic [7:0]       acc_q, acc_d;
  logic [1:0]       s;

  // Bit 1 is the ten sensor, bit 0 the five sensor; each bit has its own 2-flop chain.
  assign s = sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      state_q  <= StIdle;
      pat_q    <= 2'b00;
      cnt_q    <= '0;
      coin_q   <= 2'b00;
      reject_q <= 1'b0;
      acc_q    <= 8'd0;
    end else begin
      sync1_q  <= {sense_ten, sense_five};
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    coin_d   = 2'b00;
    reject_d = 1'b0;
    acc_d    = acc_q;
    case (state_q)
      StIdle: begin
        if (s != 2'b00) begin
          state_d = StQual;
          pat_d   = s;
          cnt_d   = '0;
        end
      end
      StQual: begin
        if (s == 2'b00) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (s != pat_q) begin
          pat_d = s;
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          // Outputs are loaded on entry so they are valid for exactly the EMIT cycle.
          state_d = StEmit;
          cnt_d   = '0;
          case (pat_q)
            2'b01: begin
              coin_d = 2'b01;
              acc_d  = acc_q + 8'd1;
            end
            2'b10: begin
              coin_d = 2'b11;
              acc_d  = acc_q + 8'd1;
            end
            default: reject_d = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEmit: begin
        state_d = StWaitRel;
        cnt_d   = '0;
      end
      StWaitRel: begin
        if (s != 2'b00) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign coin         = coin_q;
  assign reject       = reject_q;
  assign busy         = (state_q != StIdle);
  assign accepted_cnt = acc_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: edge-exact pulse timing, glitch rejection, reject path,
// release bounce, counter wrap and mid-qualification reset.
module tb_coin_acceptor;
  logic       clk = 1'b0;
  logic       rst;
  logic       sense_five;
  logic       sense_ten;
  logic [1:0] coin;
  logic       reject;
  logic       busy;
  logic [7:0] accepted_cnt;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  coin_acceptor dut (
    .clk         (clk),
    .rst         (rst),
    .sense_five  (sense_five),
    .sense_ten   (sense_ten),
    .coin        (coin),
    .reject      (reject),
    .busy        (busy),
    .accepted_cnt(accepted_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives pat (optionally switching to pat2 after edge chg_edge), releases after edge hold,
  // and records what the DUT emitted over window edges (edge 1 = first edge after drive).
  task automatic drive_insertion(input logic [1:0] pat, input int chg_edge,
                                 input logic [1:0] pat2, input int hold, input int window,
                                 output int n_coin, output int coin_edge,
                                 output logic [1:0] coin_val, output int n_rej,
                                 output int rej_edge, output int busy_last);
    n_coin = 0; coin_edge = -1; coin_val = 2'b00;
    n_rej = 0; rej_edge = -1; busy_last = 0;
    {sense_ten, sense_five} = pat;
    for (int k = 1; k <= window; k++) begin
      step();
      if (coin !== 2'b00) begin n_coin++; coin_edge = k; coin_val = coin; end
      if (reject !== 1'b0) begin n_rej++; rej_edge = k; end
      if (busy === 1'b1) busy_last = k;
      if (k == chg_edge) {sense_ten, sense_five} = pat2;
      if (k == hold) {sense_ten, sense_five} = 2'b00;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout got busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sense_five = 1'b0; sense_ten = 1'b0;
    #2;
    checks++;
    if ({coin, reject, busy, accepted_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got coin=%b rej=%b busy=%b cnt=%0d want all 0",
               coin, reject, busy, accepted_cnt);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({coin, reject, busy, accepted_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL reset_idle got coin=%b rej=%b busy=%b cnt=%0d want all 0",
               coin, reject, busy, accepted_cnt);
    end
  endtask

  task automatic test_five();
    int nc, ce, nr, re, bl; logic [1:0] cv;
    drive_insertion(2'b01, 0, 2'b00, 40, 70, nc, ce, cv, nr, re, bl);
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (nc !== 1) begin failures++; $display("FAIL five_pulses got %0d want 1", nc); end
    checks++; if (ce !== 19) begin failures++; $display("FAIL five_edge got %0d want 19", ce); end
    checks++; if (cv !== 2'b01) begin failures++; $display("FAIL five_code got %b want 01", cv); end
    checks++; if (nr !== 0) begin failures++; $display("FAIL five_reject got %0d want 0", nr); end
    checks++;
    if (accepted_cnt !== exp_cnt) begin
      failures++; $display("FAIL five_count got %0d want %0d", accepted_cnt, exp_cnt);
    end
    // Release after edge 40: 2 sync + 16 release debounce + 4 gap -> idle after edge 62.
    checks++; if (bl !== 61) begin failures++; $display("FAIL five_busy_end got %0d want 61", bl); end
    wait_idle("five");
  endtask

  task automatic test_ten();
    int nc, ce, nr, re, bl; logic [1:0] cv;
    drive_insertion(2'b10, 0, 2'b00, 40, 70, nc, ce, cv, nr, re, bl);
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (nc !== 1) begin failures++; $display("FAIL ten_pulses got %0d want 1", nc); end
    checks++; if (ce !== 19) begin failures++; $display("FAIL ten_edge got %0d want 19", ce); end
    checks++; if (cv !== 2'b11) begin failures++; $display("FAIL ten_code got %b want 11", cv); end
    checks++; if (nr !== 0) begin failures++; $display("FAIL ten_reject got %0d want 0", nr); end
    checks++;
    if (accepted_cnt !== exp_cnt) begin
      failures++; $display("FAIL ten_count got %0d want %0d", accepted_cnt, exp_cnt);
    end
    wait_idle("ten");
  endtask

  task automatic test_glitch();
    int nc, ce, nr, re, bl; logic [1:0] cv;
    drive_insertion(2'b01, 0, 2'b00, 5, 30, nc, ce, cv, nr, re, bl);
    checks++; if (nc !== 0) begin failures++; $display("FAIL glitch_coin got %0d want 0", nc); end
    checks++; if (nr !== 0) begin failures++; $display("FAIL glitch_reject got %0d want 0", nr); end
    // QUAL entered at edge 3, low seen at edge 8 -> busy last high after edge 7.
    checks++; if (bl !== 7) begin failures++; $display("FAIL glitch_busy_end got %0d want 7", bl); end
    checks++;
    if (accepted_cnt !== exp_cnt) begin
      failures++; $display("FAIL glitch_count got %0d want %0d", accepted_cnt, exp_cnt);
    end
    wait_idle("glitch");
  endtask

  task automatic test_both();
    int nc, ce, nr, re, bl; logic [1:0] cv;
    drive_insertion(2'b11, 0, 2'b00, 40, 70, nc, ce, cv, nr, re, bl);
    checks++; if (nr !== 1) begin failures++; $display("FAIL both_rej_pulses got %0d want 1", nr); end
    checks++; if (re !== 19) begin failures++; $display("FAIL both_rej_edge got %0d want 19", re); end
    checks++; if (nc !== 0) begin failures++; $display("FAIL both_coin got %0d want 0", nc); end
    checks++;
    if (accepted_cnt !== exp_cnt) begin
      failures++; $display("FAIL both_count got %0d want %0d", accepted_cnt, exp_cnt);
    end
    wait_idle("both");
  endtask

  task automatic test_pattern_change();
    int nc, ce, nr, re, bl; logic [1:0] cv;
    // 01 seen at edge 3, 11 seen at edge 11 restarts qualification -> reject at edge 27.
    drive_insertion(2'b01, 8, 2'b11, 40, 70, nc, ce, cv, nr, re, bl);
    checks++; if (nr !== 1) begin failures++; $display("FAIL chg_rej_pulses got %0d want 1", nr); end
    checks++; if (re !== 27) begin failures++; $display("FAIL chg_rej_edge got %0d want 27", re); end
    checks++; if (nc !== 0) begin failures++; $display("FAIL chg_coin got %0d want 0", nc); end
    wait_idle("chg");
  endtask

  task automatic test_bounce();
    int nc, ce, nr, bl;
    nc = 0; ce = -1; nr = 0; bl = 0;
    sense_ten = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (coin !== 2'b00) begin nc++; ce = k; end
      if (reject !== 1'b0) nr++;
      if (busy === 1'b1) bl = k;
      if (k == 40 || k == 46 || k == 51) sense_ten = 1'b0;
      if (k == 45 || k == 50) sense_ten = 1'b1;
    end
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (nc !== 1) begin failures++; $display("FAIL bounce_pulses got %0d want 1", nc); end
    checks++; if (ce !== 19) begin failures++; $display("FAIL bounce_edge got %0d want 19", ce); end
    checks++; if (nr !== 0) begin failures++; $display("FAIL bounce_reject got %0d want 0", nr); end
    // Last bounce seen at edge 53; 16 release + 4 gap -> idle after edge 73.
    checks++; if (bl !== 72) begin failures++; $display("FAIL bounce_busy_end got %0d want 72", bl); end
    checks++;
    if (accepted_cnt !== exp_cnt) begin
      failures++; $display("FAIL bounce_count got %0d want %0d", accepted_cnt, exp_cnt);
    end
    wait_idle("bounce");
  endtask

  task automatic test_wrap();
    int nc, ce, nr, re, bl; logic [1:0] cv;
    for (int i = 0; i < 256; i++) begin
      drive_insertion((i % 2 == 0) ? 2'b01 : 2'b10, 0, 2'b00, 20, 45, nc, ce, cv, nr, re, bl);
      exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (nc !== 1) begin failures++; $display("FAIL wrap_pulse_%0d got %0d want 1", i, nc); end
      checks++;
      if (accepted_cnt !== exp_cnt) begin
        failures++; $display("FAIL wrap_count_%0d got %0d want %0d", i, accepted_cnt, exp_cnt);
      end
      wait_idle("wrap");
    end
  endtask

  task automatic test_reset_mid_qual();
    int nc, ce, nr, re, bl; logic [1:0] cv;
    sense_five = 1'b1;
    // QUAL entered at edge 3 with cnt=0 -> cnt=10 after edge 13.
    for (int k = 0; k < 13; k++) step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstq_pre_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    exp_cnt = 8'd0;
    checks++;
    if ({coin, reject, busy, accepted_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL rstq_outputs got coin=%b rej=%b busy=%b cnt=%0d want all 0",
               coin, reject, busy, accepted_cnt);
    end
    step(); step();
    rst = 1'b0;
    drive_insertion(2'b01, 0, 2'b00, 40, 70, nc, ce, cv, nr, re, bl);
    exp_cnt = exp_cnt + 8'd1;
    checks++; if (nc !== 1) begin failures++; $display("FAIL rstq_pulses got %0d want 1", nc); end
    checks++; if (ce !== 19) begin failures++; $display("FAIL rstq_edge got %0d want 19", ce); end
    checks++;
    if (accepted_cnt !== exp_cnt) begin
      failures++; $display("FAIL rstq_count got %0d want %0d", accepted_cnt, exp_cnt);
    end
    wait_idle("rstq");
  endtask

  initial begin
    test_reset();
    test_five();
    test_ten();
    test_glitch();
    test_both();
    test_pattern_change();
    test_bounce();
    test_wrap();
    test_reset_mid_qual();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
